// File: rtl/if_stage_if.sv
// IF-side bundle: the IF->ID pipeline signals, ID's branch bus and the instruction SRAM port.
// master = fetch stage, slave = the ID stage plus memory environment around it.
interface if_stage_if;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: one outstanding SRAM fetch, a one-entry instruction slot
// towards ID, and a branch buffer that keeps delay-slot-first fetch ordering.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_valid;
  logic        br_buf_valid;
  logic [31:0] br_buf;
  logic [31:0] next_pc;
  logic        issue;
  logic        handshake;
  logic        fill;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_live;

  assign br_stall  = bus.br_bus[33];
  assign br_taken  = bus.br_bus[32];
  assign br_target = bus.br_bus[31:0];
  assign br_live   = br_taken & ~br_stall;

  // Handshakes: the slot moves to ID on a cycle with fs_to_ds_valid & ds_allowin; a fetch
  // request is accepted on inst_sram_req & addr_ok, and its data lands on data_ok while waiting.
  assign handshake = fs_valid & bus.ds_allowin;
  assign fill      = (state == S_WAIT) & bus.inst_sram_data_ok;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((!fs_valid || handshake) && !br_stall) begin
          issue     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.inst_sram_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.inst_sram_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A live branch wins over the buffer; the buffer covers a branch seen while we could not issue.
  always_comb begin
    next_pc = fs_pc + 32'd4;
    if (br_live)           next_pc = br_target;
    else if (br_buf_valid) next_pc = br_buf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pc        <= RESET_PC;
      fs_inst      <= 32'd0;
      fs_valid     <= 1'b0;
      br_buf_valid <= 1'b0;
      br_buf       <= 32'd0;
    end else begin
      if (issue) fs_pc <= next_pc;
      // A fill only happens into an empty slot, so it never collides with a handshake.
      if (fill) begin
        fs_inst  <= bus.inst_sram_rdata;
        fs_valid <= 1'b1;
      end else if (handshake) begin
        fs_valid <= 1'b0;
      end
      if (issue) begin
        br_buf_valid <= 1'b0;
      end else if (br_live) begin
        br_buf       <= br_target;
        br_buf_valid <= 1'b1;
      end
    end
  end

  assign bus.inst_sram_req   = (state == S_REQ) & ~reset;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'b10;
  assign bus.inst_sram_addr  = fs_pc;
  assign bus.inst_sram_wdata = 32'd0;

  // The pc half stays visible while empty: ID derives branch targets from it.
  assign bus.fs_to_ds_valid = fs_valid;
  assign bus.fs_to_ds_bus   = {(fs_valid ? fs_inst : 32'd0), fs_pc};

  assign dbg_state = state;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: an ID/branch model and an SRAM model drive the stage, and a monitor
// checks the delivered (pc, inst) stream against the expected program order.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  if_stage_if bus();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  bit wrap_seen = 1'b0;
  logic [31:0] exp_q[$];
  int phase = 0;        // 0: zero-wait, 1: ID holds off, 2: random
  bit force_wrap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: SRAM model + ID model ----------------
  initial begin : driver
    logic s_rst, s_req, s_aok, s_dok, s_valid, s_allow;
    logic [31:0] s_addr;
    logic mem_pend, holds;
    logic [31:0] mem_addr, last_pushed, tgt, br_tgt_m;
    int mem_dly, stall_cnt;
    logic stall;
    mem_pend = 1'b0; holds = 1'b0; mem_addr = '0; last_pushed = RESET_PC;
    br_tgt_m = '0; mem_dly = 0; stall_cnt = 0;
    bus.ds_allowin = 1'b0;
    bus.br_bus = '0;
    bus.inst_sram_addr_ok = 1'b1;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_req = bus.inst_sram_req; s_aok = bus.inst_sram_addr_ok;
      s_dok = bus.inst_sram_data_ok; s_valid = bus.fs_to_ds_valid; s_allow = bus.ds_allowin;
      s_addr = bus.inst_sram_addr;
      @(posedge clk);
      #1;
      if (s_rst || rst) begin
        mem_pend = 1'b0; holds = 1'b0; stall_cnt = 0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        last_pushed = RESET_PC;
        bus.ds_allowin = 1'b0;
        bus.br_bus = '0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_addr_ok = (phase == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        if (s_dok && mem_pend) mem_pend = 1'b0;
        if (s_req && s_aok) begin
          mem_pend = 1'b1;
          mem_addr = s_addr;
          mem_dly  = (phase == 2) ? $urandom_range(0, 3) : 0;
        end
        // program order: after a branch comes its delay slot, then its target
        if (s_valid && s_allow) begin
          if (holds) begin
            holds = 1'b0;
          end else if (phase == 2 && $urandom_range(0, 3) == 0) begin
            tgt = $urandom & 32'hfffffffc;
            if (force_wrap || $urandom_range(0, 7) == 0) tgt = 32'hfffffffc;
            force_wrap = 1'b0;
            exp_q.push_back(last_pushed + 32'd4);
            exp_q.push_back(tgt);
            last_pushed = tgt;
            br_tgt_m = tgt;
            holds = 1'b1;
            stall_cnt = $urandom_range(0, 3);
          end else begin
            last_pushed = last_pushed + 32'd4;
            exp_q.push_back(last_pushed);
          end
        end
        if (mem_pend) begin
          if (mem_dly == 0) begin
            bus.inst_sram_data_ok = 1'b1;
            bus.inst_sram_rdata = mem_word(mem_addr);
          end else begin
            mem_dly--;
            bus.inst_sram_data_ok = 1'b0;
            bus.inst_sram_rdata = $urandom;
          end
        end else begin
          bus.inst_sram_data_ok = (phase == 2) && ($urandom_range(0, 7) == 0);
          bus.inst_sram_rdata = $urandom;
        end
        bus.inst_sram_addr_ok = (phase == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (holds && stall_cnt > 0) begin
          stall_cnt--;
          bus.br_bus = {1'b1, 1'($urandom_range(0, 1)), 32'($urandom)};
          bus.ds_allowin = 1'b0;
        end else if (holds) begin
          bus.br_bus = {1'b0, 1'b1, br_tgt_m};
          bus.ds_allowin = (phase == 1) ? 1'b0 : (phase == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
          stall = (phase == 2) && ($urandom_range(0, 7) == 0);
          bus.br_bus = {stall, 1'b0, 32'($urandom)};
          bus.ds_allowin = (stall || phase == 1) ? 1'b0 :
                           (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic p_rst, p_valid, p_allow, p_req, p_aok, p_stall;
    logic [63:0] p_bus;
    logic [31:0] p_addr, e;
    p_rst = 1'b1; p_valid = 1'b0; p_allow = 1'b0; p_req = 1'b0; p_aok = 1'b0;
    p_stall = 1'b0; p_bus = '0; p_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!bus.fs_to_ds_valid) check("inst_zero_when_empty", 64'(bus.fs_to_ds_bus[63:32]), 64'd0);
        if (!p_rst) begin
          if (p_valid && !p_allow) begin
            check("slot_held_valid", 64'(bus.fs_to_ds_valid), 64'd1);
            check("slot_held_bus", bus.fs_to_ds_bus, p_bus);
          end
          if (p_req && !p_aok) begin
            check("req_held", 64'(bus.inst_sram_req), 64'd1);
            check("addr_held", 64'(bus.inst_sram_addr), 64'(p_addr));
          end
          if (p_stall && !p_req) check("no_req_under_stall", 64'(bus.inst_sram_req), 64'd0);
        end
        if (bus.fs_to_ds_valid && bus.ds_allowin) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL order: delivered pc %h with nothing expected", bus.fs_to_ds_bus[31:0]);
          end else begin
            e = exp_q.pop_front();
            check("deliver_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'(e));
            check("deliver_inst", 64'(bus.fs_to_ds_bus[63:32]), 64'(mem_word(e)));
            if (e == 32'd0 && bus.fs_to_ds_bus[31:0] == 32'd0) wrap_seen = 1'b1;
            delivered++;
          end
        end
      end
      p_rst = rst; p_valid = bus.fs_to_ds_valid; p_allow = bus.ds_allowin;
      p_req = bus.inst_sram_req; p_aok = bus.inst_sram_addr_ok; p_stall = bus.br_bus[33];
      p_bus = bus.fs_to_ds_bus; p_addr = bus.inst_sram_addr;
    end
  end

  // Called right after reset falls while addr_ok/data_ok are zero-wait and ID always accepts.
  task automatic release_check();
    @(negedge clk);
    check("first_req", 64'(bus.inst_sram_req), 64'd1);
    check("first_addr", 64'(bus.inst_sram_addr), 64'(RESET_PC));
    check("first_empty", 64'(bus.fs_to_ds_valid), 64'd0);
    @(negedge clk);
    check("latency_empty", 64'(bus.fs_to_ds_valid), 64'd0);
    @(negedge clk);
    check("first_valid", 64'(bus.fs_to_ds_valid), 64'd1);
    check("first_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'(RESET_PC));
    check("first_inst", 64'(bus.fs_to_ds_bus[63:32]), 64'(mem_word(RESET_PC)));
    @(negedge clk);
    check("second_req", 64'(bus.inst_sram_req), 64'd1);
    check("second_addr", 64'(bus.inst_sram_addr), 64'(RESET_PC + 32'd4));
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    logic [63:0] snap;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(bus.inst_sram_req), 64'd0);
    check("rst_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    check("rst_bus", bus.fs_to_ds_bus, {32'd0, RESET_PC});
    check("tie_wr", 64'(bus.inst_sram_wr), 64'd0);
    check("tie_size", 64'(bus.inst_sram_size), 64'd2);
    check("tie_wdata", 64'(bus.inst_sram_wdata), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    release_check();

    // ID holds off: slot must freeze and no new fetch may start
    phase = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.fs_to_ds_valid && !bus.ds_allowin) && n < 40);
    check("hold_reached", 64'(n < 40), 64'd1);
    snap = bus.fs_to_ds_bus;
    repeat (5) begin
      @(negedge clk);
      check("hold_no_req", 64'(bus.inst_sram_req), 64'd0);
      check("hold_bus", bus.fs_to_ds_bus, snap);
    end
    phase = 0;
    @(negedge clk);
    @(negedge clk);
    check("resume_req", 64'(bus.inst_sram_req), 64'd1);
    check("resume_addr", 64'(bus.inst_sram_addr), 64'(snap[31:0] + 32'd4));

    // random branches, stalls, memory delays and stray responses
    force_wrap = 1'b1;
    phase = 2;
    repeat (3000) @(negedge clk);

    // reset while a fetch is in flight
    n = 0;
    while (!(bus.inst_sram_req && bus.inst_sram_addr_ok) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("inflight_reached", 64'(n < 60), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    phase = 0;
    #1;
    check("midrst_valid", 64'(bus.fs_to_ds_valid), 64'd0);
    check("midrst_req", 64'(bus.inst_sram_req), 64'd0);
    check("midrst_pc", 64'(bus.fs_to_ds_bus[31:0]), 64'(RESET_PC));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    release_check();
    repeat (30) @(negedge clk);

    check("progress", 64'(delivered >= 200), 64'd1);
    check("wrap_exercised", 64'(wrap_seen), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the upstream end of the IF→ID interface.
- Issues instruction fetches to an SRAM-like instruction port with a request/response handshake.
- Holds one fetched instruction and presents it to ID on fs_to_ds_bus.
- Consumes ID's branch bus, including br_stall, and implements MIPS delay-slot fetch ordering.

Parameters:
- RESET_PC, 32'hbfc00000, address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_bus  in  34  {br_stall[33], br_taken[32], br_target[31:0]} from ID.
- fs_to_ds_valid  out  1  IF slot holds a valid instruction.
- fs_to_ds_bus  out  64  {fs_inst[63:32], fs_pc[31:0]}.
- inst_sram_req  out  1  fetch request.
- inst_sram_wr  out  1  tied 0.
- inst_sram_size  out  2  tied 2'b10 (word).
- inst_sram_addr  out  32  fetch address (= fs_pc).
- inst_sram_wdata  out  32  tied 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data valid this cycle.
- inst_sram_rdata  in  32  instruction word.

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-high (reset).

Registers and reset values:
- state: S_REQ.
- fs_pc: RESET_PC.
- fs_inst: 0.
- fs_valid: 0.
- br_buf_valid: 0.
- br_buf: 0.

Outputs:
- inst_sram_req = (state==S_REQ) & ~reset.
- fs_to_ds_valid = fs_valid.
- fs_to_ds_bus[31:0] = fs_pc at all times, even when fs_valid=0. ID computes branch targets from it, so it must equal the delay-slot PC whenever ID holds a branch.
- fs_to_ds_bus[63:32] = fs_inst when fs_valid, else 0.

Rules:
- At most one outstanding fetch.
- Responses are in order.

FSM:
- S_IDLE: no outstanding fetch.
  - issue = (!fs_valid | (fs_valid & ds_allowin)) & !br_stall.
  - On issue: fs_pc <= next_pc; → S_REQ.
- S_REQ: req=1, addr=fs_pc, held stable.
  - On addr_ok → S_WAIT.
- S_WAIT: on data_ok: fs_inst <= rdata; fs_valid <= 1; → S_IDLE.
  - The slot is empty on arrival by construction, because issue requires slot vacancy.
- data_ok outside S_WAIT is ignored. The memory side is reset by the same reset.

next_pc priority:
1. br_taken & !br_stall → br_target
2. br_buf_valid → br_buf
3. otherwise fs_pc + 4 (mod 2^32; 32'hfffffffc wraps to 0)

Branch buffer:
- On br_taken & !br_stall in a cycle with no issue: br_buf <= br_target; br_buf_valid <= 1. Re-latching while ID holds the branch is idempotent.
- On issue: br_buf_valid <= 0.
- br_stall=1 blocks issue entirely; the buffer is not written.

fs_valid handshake:
- Cleared on handshake (fs_valid & ds_allowin) when there is no data_ok in the same cycle.

Ordering and latency:
- The delay slot (branch_pc+4) is always fetched before the target, because the target request is only issued after the delay slot leaves IF.
- Latency: issue cycle t → req at t+1 → earliest data at t+2 → fs_to_ds_valid at t+3.

Reset:
- Reset mid-operation (any state) returns to reset values immediately.
- Any in-flight fetch is abandoned.

Test Plan:
1. Release reset, memory with zero-wait addr_ok and 1-cycle data_ok → first req addr 32'hbfc00000. fs_to_ds_valid with pc bfc00000 and the correct inst. Next req is bfc00004.
2. Hold ds_allowin=0 for 5 cycles with fs_valid=1 → no new req, bus stable. Raise ds_allowin → next fetch issues that cycle.
3. ID branch at bfc00010 with br_taken=1, br_target=bfc00100 while delay slot bfc00014 is in S_WAIT → bfc00014 is delivered first, then req bfc00100. br_buf_valid clears at issue.
4. br_stall=1 for 3 cycles, then br_taken=1 with target 80000000 → no req during the stall; the next req is 80000000, never the delay-slot address + 4.
5. Stress addr_ok delayed 4 cycles and data_ok delayed 3 → req and addr stay stable until accepted. Stray data_ok in S_IDLE is ignored, with no slot change.
6. Assert reset during S_WAIT → fs_valid=0 and req=0 during reset. After release, fetch restarts at RESET_PC. Also check fs_pc=fffffffc sequential → next req 00000000.
